// File: rtl/wifi_tx_mapper_multimod.sv
// Serial-bit constellation mapper for BPSK/QPSK/16-QAM/64-QAM with 802.11 Gray levels.
// Gathers N_BPSC bits per symbol and presents a registered I/Q pair under valid/ready.
module wifi_tx_mapper_multimod #(
    parameter int DATA_W  = 12,
    parameter int K_BPSK  = 512,
    parameter int K_QPSK  = 362,
    parameter int K_16QAM = 162,
    parameter int K_64QAM = 79
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mode,
    input  logic              flush,
    input  logic              valid_in,
    input  logic              data_in,
    output logic              ready_in,
    output logic              valid_out,
    input  logic              ready_out,
    output logic [DATA_W-1:0] data_out_real,
    output logic [DATA_W-1:0] data_out_imag,
    output logic [15:0]       sym_count
);

    localparam int MAX_MAG = (1 << (DATA_W - 1)) - 1;

    if (K_BPSK > MAX_MAG || K_QPSK > MAX_MAG || 3 * K_16QAM > MAX_MAG || 7 * K_64QAM > MAX_MAG)
    begin : g_range_err
        $error("wifi_tx_mapper_multimod: constellation level exceeds DATA_W range");
    end

    localparam logic [DATA_W-1:0] B_P   = DATA_W'(K_BPSK);
    localparam logic [DATA_W-1:0] B_N   = DATA_W'(-K_BPSK);
    localparam logic [DATA_W-1:0] Q_P   = DATA_W'(K_QPSK);
    localparam logic [DATA_W-1:0] Q_N   = DATA_W'(-K_QPSK);
    localparam logic [DATA_W-1:0] S_P1  = DATA_W'(K_16QAM);
    localparam logic [DATA_W-1:0] S_N1  = DATA_W'(-K_16QAM);
    localparam logic [DATA_W-1:0] S_P3  = DATA_W'(3 * K_16QAM);
    localparam logic [DATA_W-1:0] S_N3  = DATA_W'(-3 * K_16QAM);
    localparam logic [DATA_W-1:0] Z_P1  = DATA_W'(K_64QAM);
    localparam logic [DATA_W-1:0] Z_N1  = DATA_W'(-K_64QAM);
    localparam logic [DATA_W-1:0] Z_P3  = DATA_W'(3 * K_64QAM);
    localparam logic [DATA_W-1:0] Z_N3  = DATA_W'(-3 * K_64QAM);
    localparam logic [DATA_W-1:0] Z_P5  = DATA_W'(5 * K_64QAM);
    localparam logic [DATA_W-1:0] Z_N5  = DATA_W'(-5 * K_64QAM);
    localparam logic [DATA_W-1:0] Z_P7  = DATA_W'(7 * K_64QAM);
    localparam logic [DATA_W-1:0] Z_N7  = DATA_W'(-7 * K_64QAM);

    function automatic logic [DATA_W-1:0] qam16_lvl(input logic [1:0] b);
        case (b)
            2'b00:   return S_N3;
            2'b01:   return S_N1;
            2'b11:   return S_P1;
            default: return S_P3;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] qam64_lvl(input logic [2:0] b);
        case (b)
            3'b000:  return Z_N7;
            3'b001:  return Z_N5;
            3'b011:  return Z_N3;
            3'b010:  return Z_N1;
            3'b110:  return Z_P1;
            3'b111:  return Z_P3;
            3'b101:  return Z_P5;
            default: return Z_P7;
        endcase
    endfunction

    // Only the first N_BPSC-1 bits need storing; the last bit is mapped straight from data_in.
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [4:0]        shreg_q, shreg_d;
    logic [1:0]        mode_lat_q, mode_lat_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] real_q, real_d, imag_q, imag_d;
    logic [15:0]       sym_cnt_q, sym_cnt_d;

    logic              accept, complete;
    logic [1:0]        eff_mode;
    logic [2:0]        last_idx;
    logic [5:0]        bits;
    logic [DATA_W-1:0] map_i, map_q;

    assign ready_in      = !valid_q || ready_out;
    assign valid_out     = valid_q;
    assign data_out_real = real_q;
    assign data_out_imag = imag_q;
    assign sym_count     = sym_cnt_q;

    always_comb begin
        accept   = valid_in && ready_in && !flush;
        eff_mode = (bit_cnt_q == 3'd0) ? mode : mode_lat_q;
        case (eff_mode)
            2'b00:   last_idx = 3'd0;
            2'b01:   last_idx = 3'd1;
            2'b10:   last_idx = 3'd3;
            default: last_idx = 3'd5;
        endcase
        complete = accept && (bit_cnt_q == last_idx);
        bits     = {shreg_q, data_in};

        map_i = '0;
        map_q = '0;
        case (eff_mode)
            2'b00: map_i = bits[0] ? B_P : B_N;
            2'b01: begin
                map_i = bits[1] ? Q_P : Q_N;
                map_q = bits[0] ? Q_P : Q_N;
            end
            2'b10: begin
                map_i = qam16_lvl(bits[3:2]);
                map_q = qam16_lvl(bits[1:0]);
            end
            default: begin
                map_i = qam64_lvl(bits[5:3]);
                map_q = qam64_lvl(bits[2:0]);
            end
        endcase

        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        mode_lat_d = mode_lat_q;
        sym_cnt_d  = sym_cnt_q;
        valid_d    = valid_q;
        real_d     = real_q;
        imag_d     = imag_q;

        if (flush) begin
            bit_cnt_d = '0;
            shreg_d   = '0;
            sym_cnt_d = '0;
        end else if (accept) begin
            if (bit_cnt_q == 3'd0) mode_lat_d = mode;
            if (complete) begin
                bit_cnt_d = '0;
                shreg_d   = '0;
                sym_cnt_d = sym_cnt_q + 16'd1;
            end else begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                shreg_d   = bits[4:0];
            end
        end

        if (complete) begin
            valid_d = 1'b1;
            real_d  = map_i;
            imag_d  = map_q;
        end else if (ready_out) begin
            valid_d = 1'b0;
            real_d  = '0;
            imag_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            mode_lat_q <= '0;
            sym_cnt_q  <= '0;
            valid_q    <= 1'b0;
            real_q     <= '0;
            imag_q     <= '0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            mode_lat_q <= mode_lat_d;
            sym_cnt_q  <= sym_cnt_d;
            valid_q    <= valid_d;
            real_q     <= real_d;
            imag_q     <= imag_d;
        end
    end

endmodule

// File: tb/tb_wifi_tx_mapper_multimod.sv
// Directed bench for wifi_tx_mapper_multimod; observation vector is
// {ready_in, valid_out, data_out_real, data_out_imag, sym_count}.
module tb_wifi_tx_mapper_multimod;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  mode = 2'b00;
    logic        flush = 1'b0;
    logic        valid_in = 1'b0;
    logic        data_in = 1'b0;
    logic        ready_out = 1'b0;
    logic        ready_in, valid_out;
    logic [11:0] data_out_real, data_out_imag;
    logic [15:0] sym_count;
    logic [41:0] obs;
    logic [41:0] exp_v;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    wifi_tx_mapper_multimod dut (
        .clk(clk), .reset(reset), .mode(mode), .flush(flush),
        .valid_in(valid_in), .data_in(data_in), .ready_in(ready_in),
        .valid_out(valid_out), .ready_out(ready_out),
        .data_out_real(data_out_real), .data_out_imag(data_out_imag),
        .sym_count(sym_count)
    );

    assign obs = {ready_in, valid_out, data_out_real, data_out_imag, sym_count};

    task automatic send_bit(input logic b);
        valid_in = 1'b1;
        data_in  = b;
        @(posedge clk); #1;
        valid_in = 1'b0;
        data_in  = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        exp_v = {1'b1, 1'b0, 12'h000, 12'h000, 16'd0};
        n_total++;
        if (obs !== exp_v) $display("FAIL reset_state: got %h exp %h", obs, exp_v);
        else n_pass++;
        @(negedge clk) reset = 1'b1;
    endtask

    task automatic test_qpsk();
        mode = 2'b01; ready_out = 1'b1;
        send_bit(1'b1);
        exp_v = {1'b1, 1'b0, 12'h000, 12'h000, 16'd0};
        n_total++;
        if (obs !== exp_v) $display("FAIL qpsk_partial: got %h exp %h", obs, exp_v);
        else n_pass++;
        send_bit(1'b0);
        exp_v = {1'b1, 1'b1, 12'h16A, 12'hE96, 16'd1};
        n_total++;
        if (obs !== exp_v) $display("FAIL qpsk_sym: got %h exp %h", obs, exp_v);
        else n_pass++;
        idle();
        exp_v = {1'b1, 1'b0, 12'h000, 12'h000, 16'd1};
        n_total++;
        if (obs !== exp_v) $display("FAIL qpsk_drain: got %h exp %h", obs, exp_v);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        mode = 2'b00;
        send_bit(1'b0);
        exp_v = {1'b1, 1'b1, 12'hE00, 12'h000, 16'd2};
        n_total++;
        if (obs !== exp_v) $display("FAIL bpsk_sym0: got %h exp %h", obs, exp_v);
        else n_pass++;
        send_bit(1'b1);
        exp_v = {1'b1, 1'b1, 12'h200, 12'h000, 16'd3};
        n_total++;
        if (obs !== exp_v) $display("FAIL bpsk_sym1: got %h exp %h", obs, exp_v);
        else n_pass++;
        idle();
        exp_v = {1'b1, 1'b0, 12'h000, 12'h000, 16'd3};
        n_total++;
        if (obs !== exp_v) $display("FAIL bpsk_drain: got %h exp %h", obs, exp_v);
        else n_pass++;
    endtask

    task automatic test_qam();
        mode = 2'b10;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
        exp_v = {1'b1, 1'b0, 12'h000, 12'h000, 16'd3};
        n_total++;
        if (obs !== exp_v) $display("FAIL qam16_partial: got %h exp %h", obs, exp_v);
        else n_pass++;
        send_bit(1'b1);
        exp_v = {1'b1, 1'b1, 12'h1E6, 12'hF5E, 16'd4};
        n_total++;
        if (obs !== exp_v) $display("FAIL qam16_sym: got %h exp %h", obs, exp_v);
        else n_pass++;
        idle();
        mode = 2'b11;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
        send_bit(1'b0); send_bit(1'b1);
        exp_v = {1'b1, 1'b0, 12'h000, 12'h000, 16'd4};
        n_total++;
        if (obs !== exp_v) $display("FAIL qam64_partial: got %h exp %h", obs, exp_v);
        else n_pass++;
        send_bit(1'b1);
        exp_v = {1'b1, 1'b1, 12'h229, 12'hF13, 16'd5};
        n_total++;
        if (obs !== exp_v) $display("FAIL qam64_sym: got %h exp %h", obs, exp_v);
        else n_pass++;
        idle();
        exp_v = {1'b1, 1'b0, 12'h000, 12'h000, 16'd5};
        n_total++;
        if (obs !== exp_v) $display("FAIL qam64_drain: got %h exp %h", obs, exp_v);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        mode = 2'b01;
        send_bit(1'b1); send_bit(1'b1);
        exp_v = {1'b1, 1'b1, 12'h16A, 12'h16A, 16'd6};
        n_total++;
        if (obs !== exp_v) $display("FAIL bp_first_sym: got %h exp %h", obs, exp_v);
        else n_pass++;
        ready_out = 1'b0;
        valid_in  = 1'b1;
        data_in   = 1'b0;
        #1;
        exp_v = {1'b0, 1'b1, 12'h16A, 12'h16A, 16'd6};
        n_total++;
        if (obs !== exp_v) $display("FAIL bp_ready_low: got %h exp %h", obs, exp_v);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_total++;
            if (obs !== exp_v) $display("FAIL bp_hold cycle %0d: got %h exp %h", i, obs, exp_v);
            else n_pass++;
        end
        ready_out = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        exp_v = {1'b1, 1'b0, 12'h000, 12'h000, 16'd6};
        n_total++;
        if (obs !== exp_v) $display("FAIL bp_release: got %h exp %h", obs, exp_v);
        else n_pass++;
        send_bit(1'b1);
        exp_v = {1'b1, 1'b1, 12'hE96, 12'h16A, 16'd7};
        n_total++;
        if (obs !== exp_v) $display("FAIL bp_next_sym: got %h exp %h", obs, exp_v);
        else n_pass++;
        idle();
    endtask

    task automatic test_mode_switch();
        mode = 2'b10;
        send_bit(1'b1); send_bit(1'b1);
        mode = 2'b01;
        send_bit(1'b0);
        exp_v = {1'b1, 1'b0, 12'h000, 12'h000, 16'd7};
        n_total++;
        if (obs !== exp_v) $display("FAIL modesw_partial: got %h exp %h", obs, exp_v);
        else n_pass++;
        send_bit(1'b0);
        exp_v = {1'b1, 1'b1, 12'h0A2, 12'hE1A, 16'd8};
        n_total++;
        if (obs !== exp_v) $display("FAIL modesw_sym: got %h exp %h", obs, exp_v);
        else n_pass++;
        idle();
    endtask

    task automatic test_flush();
        mode = 2'b11;
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        flush = 1'b1; valid_in = 1'b1; data_in = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; valid_in = 1'b0; data_in = 1'b0;
        exp_v = {1'b1, 1'b0, 12'h000, 12'h000, 16'd0};
        n_total++;
        if (obs !== exp_v) $display("FAIL flush_clear: got %h exp %h", obs, exp_v);
        else n_pass++;
        mode = 2'b01;
        send_bit(1'b0);
        n_total++;
        if (obs !== exp_v) $display("FAIL flush_partial: got %h exp %h", obs, exp_v);
        else n_pass++;
        send_bit(1'b1);
        exp_v = {1'b1, 1'b1, 12'hE96, 12'h16A, 16'd1};
        n_total++;
        if (obs !== exp_v) $display("FAIL flush_next_sym: got %h exp %h", obs, exp_v);
        else n_pass++;
        ready_out = 1'b0;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        exp_v = {1'b0, 1'b1, 12'hE96, 12'h16A, 16'd0};
        n_total++;
        if (obs !== exp_v) $display("FAIL flush_keeps_output: got %h exp %h", obs, exp_v);
        else n_pass++;
        ready_out = 1'b1;
        idle();
        exp_v = {1'b1, 1'b0, 12'h000, 12'h000, 16'd0};
        n_total++;
        if (obs !== exp_v) $display("FAIL flush_drain: got %h exp %h", obs, exp_v);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        mode = 2'b01;
        send_bit(1'b1); send_bit(1'b0);
        ready_out = 1'b0;
        #2 reset = 1'b0;
        #1;
        exp_v = {1'b1, 1'b0, 12'h000, 12'h000, 16'd0};
        n_total++;
        if (obs !== exp_v) $display("FAIL async_reset_out: got %h exp %h", obs, exp_v);
        else n_pass++;
        @(negedge clk) reset = 1'b1;
        ready_out = 1'b1;
        send_bit(1'b0);
        #3 reset = 1'b0;
        @(negedge clk) reset = 1'b1;
        send_bit(1'b1);
        n_total++;
        if (obs !== exp_v) $display("FAIL reset_partial_lost: got %h exp %h", obs, exp_v);
        else n_pass++;
        send_bit(1'b1);
        exp_v = {1'b1, 1'b1, 12'h16A, 12'h16A, 16'd1};
        n_total++;
        if (obs !== exp_v) $display("FAIL reset_next_sym: got %h exp %h", obs, exp_v);
        else n_pass++;
        idle();
    endtask

    initial begin
        test_reset();
        test_qpsk();
        test_back_to_back();
        test_qam();
        test_backpressure();
        test_mode_switch();
        test_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/wifi_tx_mapper_multimod.md
Name: wifi_tx_mapper_multimod

Overview:
- Parametrised constellation mapper for the WiFi TX chain; successor to the fixed QPSK mapper.
- Accepts one coded/interleaved bit per cycle and gathers N_BPSC bits per symbol (1/2/4/6).
- Emits a signed I/Q symbol for BPSK, QPSK, 16-QAM or 64-QAM (802.11 Gray mapping), with valid/ready backpressure toward the IFFT loader.

Parameters:
- DATA_W, 12, output sample width (two's complement).
- K_BPSK, 512, BPSK amplitude (unit scale).
- K_QPSK, 362, QPSK unit step (512/sqrt2).
- K_16QAM, 162, 16-QAM unit step (512/sqrt10).
- K_64QAM, 79, 64-QAM unit step (512/sqrt42).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- mode  in  2  00 BPSK, 01 QPSK, 10 16-QAM, 11 64-QAM
- flush  in  1  synchronous clear of a partial symbol
- valid_in  in  1  data_in qualifier
- data_in  in  1  serial coded bit
- ready_in  out  1  mapper can accept a bit this cycle
- valid_out  out  1  symbol valid
- ready_out  in  1  downstream accepts the symbol
- data_out_real  out  DATA_W  I sample
- data_out_imag  out  DATA_W  Q sample
- sym_count  out  16  symbols emitted since reset or flush, wraps

Behaviour:
- Reset values: valid_out=0, data_out_real=0, data_out_imag=0, sym_count=0, bit counter=0, shift register=0. ready_in=1 after reset.
- Handshake: ready_in = !valid_out || ready_out. A bit is accepted when valid_in && ready_in.
- Mode latch: mode is sampled with the first bit of each symbol (bit counter=0) and held until that symbol completes. A mode change mid-symbol has no effect until the next symbol.
- Bit order: the first accepted bit is b0. Bits shift in MSB-first, so the I group is the first N_BPSC/2 bits. This matches the QPSK rule: b0→I, b1→Q.
- Completion: when the bit counter reaches N_BPSC-1 and a bit is accepted, the symbol is mapped and registered. valid_out=1 on the next edge (latency 1 cycle from the last bit). The counter returns to 0 and sym_count increments.
- Hold: while valid_out && !ready_out, data_out_* and valid_out hold and ready_in=0.
- Drain: if ready_out=1 and no new symbol completes, valid_out drops to 0 and data_out_* go to 0 on the next edge.
- Back-to-back: a new symbol completing in the same cycle as ready_out replaces the output with no bubble.
- Levels: a bit value of 0 maps to the negative side.
  - BPSK: b0 0→-K_BPSK, 1→+K_BPSK; Q=0.
  - QPSK: per axis 0→-1, 1→+1 (×K_QPSK).
  - 16-QAM, per axis 2 bits: 00→-3, 01→-1, 11→+1, 10→+3 (×K_16QAM).
  - 64-QAM, per axis 3 bits: 000→-7, 001→-5, 011→-3, 010→-1, 110→+1, 111→+3, 101→+5, 100→+7 (×K_64QAM).
- Arithmetic:
  - Products are precomputed constants; no runtime multiplier.
  - Maximum magnitude is 553, which fits DATA_W≥11. Elaborate-time error if a K×max level exceeds 2^(DATA_W-1)-1.
- Flush:
  - Clears the bit counter, shift register and sym_count on the next edge.
  - A pending output symbol is not dropped; it is still held until ready_out.
  - A bit presented in the flush cycle is discarded.
- valid_in low mid-symbol: partial bits are retained indefinitely; no timeout.
- Reset mid-symbol: all state returns to reset values immediately (asynchronous); partial bits are lost.

Test Plan:
- QPSK, ready_out=1, bits 1,0 → one cycle after the 2nd bit: valid_out=1, I=0x16A (+362), Q=0xE96 (-362), sym_count=1.
- BPSK, bits 0,1 → two consecutive symbols: I=0xE00 (-512), Q=0x000; then I=0x200, Q=0x000; valid_out high on both cycles with no bubble.
- 16-QAM, bits 1,0,0,1 → I=0x1E6 (+486), Q=0xF5E (-162). 64-QAM, bits 1,0,0,0,1,1 → I=0x229 (+553), Q=0xF13 (-237).
- Backpressure: QPSK stream with ready_out held low for 5 cycles after the first symbol → outputs are stable, ready_in=0, no bits are accepted; on release the next symbol follows normally.
- Mode switch and flush:
  - mode changed 10→01 after 2 of 4 bits → the symbol still completes as 16-QAM.
  - flush after 3 of 6 64-QAM bits → partial bits are discarded and sym_count=0; the next 2 bits form a QPSK symbol.
- Reset asserted after 1 of 2 QPSK bits → all outputs are 0 immediately; after release, bits 1,1 → I=Q=0x16A.
